// File: rtl/cis_pkg.sv
// Shared types and helpers for the pixel readout capture path: capture FSM states,
// default geometry constants and the saturating CDS subtraction.
package cis_pkg;

  typedef enum logic [1:0] {IDLE, REF, ARMED, READOUT} capture_state_t;

  localparam int DEF_PIXEL_COUNT = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  // Working width of cds_sub; callers zero-extend narrower samples into it.
  localparam int CDS_W           = 16;

  function automatic logic [CDS_W-1:0] cds_sub(input logic [CDS_W-1:0] sample,
                                               input logic [CDS_W-1:0] ref_val);
    return (ref_val > sample) ? '0 : sample - ref_val;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding {last, data} entries for the readout stream.
// Pointers wrap naturally (DEPTH is a power of two); a push while full is accepted only with a same-cycle pop.
module pixel_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  // Gated so the output reads zero whenever nothing is held, including right after reset.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pixel_readout_capture.sv
// Receive side of the sensor sequencer: tracks corr/read/erase phases, captures read-phase pixels,
// optionally applies CDS against references latched at end of CORR (enabled by CIS_CDS_EN), streams out via FIFO.
module pixel_readout_capture
  import cis_pkg::*;
#(
  parameter int PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              erase,
  input  logic                              corr,
  input  logic                              convert,
  input  logic                              read,
  input  logic [$clog2(PIXEL_COUNT)-1:0]    pixel_select,
  input  logic [PIXEL_COUNT*DATA_WIDTH-1:0] adc_bus,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              overflow,
  output logic                              frame_done
);

  localparam int                SEL_W     = $clog2(PIXEL_COUNT);
  localparam logic [SEL_W:0]    PIX_LIMIT = (SEL_W+1)'(PIXEL_COUNT);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(PIXEL_COUNT-1);

  capture_state_t        state;
  logic                  erase_q;
  logic [DATA_WIDTH-1:0] lane [PIXEL_COUNT];
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] result_p0;
  logic                  vld_p0;
  logic                  last_p0;
  logic                  fifo_full;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  drop;
  logic [DATA_WIDTH:0]   fifo_q;

  for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_lane
    assign lane[i] = adc_bus[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Capture stage: select the addressed lane and form the result pushed this edge
  assign sample  = lane[pixel_select];
  assign vld_p0  = read && ({1'b0, pixel_select} < PIX_LIMIT);
  assign last_p0 = (pixel_select == LAST_SEL);
  assign pop_ok  = out_valid && out_ready;
  assign push_ok = vld_p0 && (!fifo_full || pop_ok);
  assign drop    = vld_p0 && fifo_full && !pop_ok;

`ifdef CIS_CDS_EN
  logic [PIXEL_COUNT*DATA_WIDTH-1:0] corr_bus;
  logic [PIXEL_COUNT*DATA_WIDTH-1:0] ref_bus;
  logic [DATA_WIDTH-1:0]             ref_lane [PIXEL_COUNT];
  logic [DATA_WIDTH-1:0]             ref_sel;
  logic [CDS_W-1:0]                  cds_full;
  logic [CDS_W-DATA_WIDTH:0]         unused_bits;

  for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_ref_lane
    assign ref_lane[i] = ref_bus[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // corr_bus follows the ADC while corr is high; its last value becomes the reference when corr drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_bus <= '0;
      ref_bus  <= '0;
    end else begin
      if (corr) corr_bus <= adc_bus;
      if (state == REF && !corr) ref_bus <= corr_bus;
    end
  end

  // Reads outside an armed frame have no valid reference and subtract nothing.
  assign ref_sel     = (state == ARMED || state == READOUT) ? ref_lane[pixel_select] : '0;
  assign cds_full    = cds_sub(CDS_W'(sample), CDS_W'(ref_sel));
  assign result_p0   = cds_full[DATA_WIDTH-1:0];
  assign unused_bits = {convert, cds_full[CDS_W-1:DATA_WIDTH]};
`else
  logic unused_bits;
  assign result_p0   = sample;
  assign unused_bits = convert;
`endif

  // Sequencing and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      erase_q    <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      erase_q    <= erase;
      frame_done <= push_ok && last_p0;
      if (drop)                overflow <= 1'b1;
      else if (erase && !erase_q) overflow <= 1'b0;
      case (state)
        IDLE:    if (corr) state <= REF;
        REF:     if (!corr) state <= ARMED;
        ARMED: begin
          if (erase)     state <= IDLE;
          else if (corr) state <= REF;
          else if (read) state <= READOUT;
        end
        READOUT: if (!read) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pixel_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (vld_p0),
    .push_data({last_p0, result_p0}),
    .pop      (out_ready),
    .pop_data (fifo_q),
    .valid    (out_valid),
    .full     (fifo_full)
  );

  assign out_data = fifo_q[DATA_WIDTH-1:0];
  assign out_last = fifo_q[DATA_WIDTH];

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Randomized frame-level bench for pixel_readout_capture with a queue-based reference model.
module tb_pixel_readout_capture;

  localparam int PC = 4;
  localparam int DW = 8;
  localparam int FD = 4;
`ifdef CIS_CDS_EN
  localparam bit CDS_ON = 1'b1;
`else
  localparam bit CDS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        erase, corr, convert, read, out_ready;
  logic [1:0]  pixel_select;
  logic [31:0] adc_bus;
  logic [7:0]  out_data;
  logic        out_valid, out_last, overflow, frame_done;

  always #5 clk = ~clk;

  pixel_readout_capture #(
    .PIXEL_COUNT(PC),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .erase       (erase),
    .corr        (corr),
    .convert     (convert),
    .read        (read),
    .pixel_select(pixel_select),
    .adc_bus     (adc_bus),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .overflow    (overflow),
    .frame_done  (frame_done)
  );

  int          total = 0;
  int          bad   = 0;
  logic [8:0]  q[$];
  bit          ovf_m, fd_m, erase_prev, ref_active;
  logic [31:0] ref_m;
  int          rdy_mode;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expected_pixel(input logic [7:0] s, input logic [7:0] r);
    int d;
    d = int'(s) - (CDS_ON ? int'(r) : 0);
    return (d < 0) ? 8'd0 : 8'(d);
  endfunction

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check what the previous edge produced, drive new inputs, advance the model.
  task automatic step(input logic e, input logic c, input logic rd,
                      input logic [1:0] sel, input logic [31:0] bus);
    logic       rdy;
    bit         pop;
    logic [7:0] lane, rv;
    @(negedge clk);
    check_val("out_valid", out_valid, 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_val("out_data", out_data, 32'(q[0][7:0]));
      check_val("out_last", out_last, 32'(q[0][8]));
    end
    check_val("overflow", overflow, 32'(ovf_m));
    check_val("frame_done", frame_done, 32'(fd_m));
    rdy = pick_rdy();
    erase = e; corr = c; read = rd; pixel_select = sel; adc_bus = bus;
    out_ready = rdy; convert = 1'($urandom_range(0, 1));
    pop  = (q.size() != 0) && rdy;
    fd_m = 1'b0;
    if (e && !erase_prev) ovf_m = 1'b0;
    erase_prev = e;
    if (rd && q.size() == FD && !pop) ovf_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (rd && q.size() < FD) begin
      lane = bus[sel*8 +: 8];
      rv   = ref_active ? ref_m[sel*8 +: 8] : 8'd0;
      q.push_back({sel == 2'd3, expected_pixel(lane, rv)});
      fd_m = (sel == 2'd3);
    end
  endtask

  task automatic mid_reset();
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_frame_done", frame_done, 0);
    q.delete();
    ovf_m = 0; fd_m = 0; erase_prev = 0; ref_active = 0;
    erase = 0; corr = 0; read = 0; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode: 0 ready, 1 random ready, 2 stalled, 3 stalled until reads then ready
  task automatic run_frame(input logic [31:0] refs, input logic [31:0] pix, input bit use_corr,
                           input bit abort, input int mode, input int rst_at);
    logic [31:0] bus;
    int          n;
    rdy_mode = (mode == 3) ? 2 : mode;
    step(1, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, $urandom);
    if (use_corr) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n - 1; i++) step(0, 1, 0, 0, $urandom);
      step(0, 1, 0, 0, refs);
      ref_m = refs;
      step(0, 0, 0, 0, $urandom);
      step(0, 0, 0, 0, $urandom);
      if (abort) begin
        step(1, 0, 0, 0, $urandom);
        step(0, 0, 0, 0, $urandom);
      end else begin
        ref_active = 1'b1;
      end
    end
    if (mode == 3) rdy_mode = 0;
    for (int i = 0; i < PC; i++) begin
      if (i == rst_at) begin
        mid_reset();
        return;
      end
      bus = $urandom;
      bus[i*8 +: 8] = pix[i*8 +: 8];
      step(0, 0, 1, 2'(i), bus);
    end
    step(0, 0, 0, 0, $urandom);
    ref_active = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 0;
    repeat (FD + 3) step(0, 0, 0, 0, $urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    erase = 0; corr = 0; convert = 0; read = 0; out_ready = 1'b1;
    pixel_select = 0; adc_bus = 0;
    ovf_m = 0; fd_m = 0; erase_prev = 0; ref_active = 0; ref_m = 0; rdy_mode = 0;
    #1;
    check_val("init_valid", out_valid, 0);
    check_val("init_data", out_data, 0);
    check_val("init_last", out_last, 0);
    check_val("init_overflow", overflow, 0);
    check_val("init_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // refs {10,20,30,40}, read-phase {50,25,30,100}
    run_frame({8'd40, 8'd30, 8'd20, 8'd10}, {8'd100, 8'd30, 8'd25, 8'd50}, 1, 0, 0, -1);
    drain();
    // saturation: ref 200 above sample 100
    run_frame(32'hC8C8_C8C8, 32'h6464_6464, 1, 0, 0, -1);
    drain();
    // backpressure: fill, overflow on second frame, then full with simultaneous pop
    run_frame($urandom, $urandom, 1, 0, 2, -1);
    run_frame($urandom, $urandom, 1, 0, 2, -1);
    run_frame($urandom, $urandom, 1, 0, 3, -1);
    drain();
    // read with no reference, and reference abandoned by erase in ARMED
    run_frame($urandom, $urandom, 0, 0, 0, -1);
    run_frame($urandom, $urandom, 1, 1, 1, -1);
    drain();
    // reset in the middle of a stalled readout, then a clean frame
    run_frame($urandom, $urandom, 1, 0, 2, 2);
    run_frame($urandom, $urandom, 1, 0, 0, -1);
    drain();

    for (int f = 0; f < 40; f++) begin
      run_frame($urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
